// File: rtl/mem_arbiter.sv
// Round-robin N-master to 1-slave memory arbiter with one outstanding transaction,
// zero-cycle response pass-through and a per-transaction timeout error response.
module mem_arbiter #(
  parameter int          NUM_MASTERS = 2,
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          TIMEOUT     = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hDEADBEEF,
  localparam int         GNT_W       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_MASTERS-1:0]          m_reqValid,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [NUM_MASTERS*2-1:0]        m_size,
  input  logic [NUM_MASTERS-1:0]          m_wen,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [NUM_MASTERS*DATA_W/8-1:0] m_wmask,
  output logic [NUM_MASTERS-1:0]          m_respValid,
  output logic [DATA_W-1:0]               m_rdata,
  output logic                            m_err,
  output logic                            s_reqValid,
  output logic [ADDR_W-1:0]               s_addr,
  output logic [1:0]                      s_size,
  output logic                            s_wen,
  output logic [DATA_W-1:0]               s_wdata,
  output logic [DATA_W/8-1:0]             s_wmask,
  input  logic                            s_respValid,
  input  logic [DATA_W-1:0]               s_rdata,
  output logic [GNT_W-1:0]                grant,
  output logic                            late_resp
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_DATA);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state_q, state_d;
  logic [GNT_W-1:0]     grant_q, grant_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [1:0]           size_q, size_d;
  logic                 wen_q, wen_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W/8-1:0]  wmask_q, wmask_d;
  logic                 late_q, late_d;

  logic                 pick_found;
  logic [GNT_W-1:0]     pick_idx;
  logic [GNT_W-1:0]     cand_idx;
  logic                 resp_fire;
  logic                 tmo_fire;

  // Round-robin pick: first requester scanning upward from the slot after grant.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = grant_q;
    cand_idx   = grant_q;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand_idx = GNT_W'((int'(grant_q) + off) % NUM_MASTERS);
      if (!pick_found && m_reqValid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wen_d     = wen_q;
    wdata_d   = wdata_q;
    wmask_d   = wmask_q;
    late_d    = late_q | ((state_q == IDLE) && s_respValid);
    resp_fire = 1'b0;
    tmo_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = WAIT;
          grant_d = pick_idx;
          cnt_d   = '0;
          addr_d  = m_addr[pick_idx*ADDR_W +: ADDR_W];
          size_d  = m_size[pick_idx*2 +: 2];
          wen_d   = m_wen[pick_idx];
          wdata_d = m_wdata[pick_idx*DATA_W +: DATA_W];
          wmask_d = m_wmask[pick_idx*(DATA_W/8) +: DATA_W/8];
        end
      end
      WAIT: begin
        // A slave answer in the last timeout cycle takes precedence over the error.
        if (s_respValid) begin
          resp_fire = 1'b1;
          state_d   = IDLE;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= GNT_W'(NUM_MASTERS - 1);
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      late_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      wen_q   <= wen_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      late_q  <= late_d;
    end
  end

  always_comb begin
    m_respValid = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if ((resp_fire || tmo_fire) && (grant_q == GNT_W'(i))) m_respValid[i] = 1'b1;
    end
  end

  assign m_rdata    = tmo_fire ? ERR_WORD : s_rdata;
  assign m_err      = tmo_fire;
  assign s_reqValid = (state_q == WAIT);
  assign s_addr     = addr_q;
  assign s_size     = size_q;
  assign s_wen      = wen_q;
  assign s_wdata    = wdata_q;
  assign s_wmask    = wmask_q;
  assign grant      = grant_q;
  assign late_resp  = late_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Parametrised N-master to 1-slave memory request arbiter. Generalises the CPU's separate IFU and LSU memory ports onto a single shared bus.
- Uses the same reqValid/respValid handshake the core already uses.
- Arbitration is round-robin. One transaction is outstanding at a time.
- A per-transaction timeout returns an error response when the slave never answers.

Parameters:
NUM_MASTERS, 2, number of requesters (index 0 = IFU, 1 = LSU in the default core); range 1..8
ADDR_W, 32, address width
DATA_W, 32, data width; multiple of 8
TIMEOUT, 1024, cycles in WAIT before error response; 0 disables timeout
ERR_DATA, 32'hDEADBEEF, rdata returned on timeout

Ports:
clock  in  1  clock
reset  in  1  asynchronous, active-high reset
m_reqValid  in  NUM_MASTERS  per-master request; held high until that master's m_respValid
m_addr  in  NUM_MASTERS*ADDR_W  packed addresses, master i at [i*ADDR_W +: ADDR_W]
m_size  in  NUM_MASTERS*2  packed size (0=B, 1=H, 2=W)
m_wen  in  NUM_MASTERS  write enable
m_wdata  in  NUM_MASTERS*DATA_W  packed write data
m_wmask  in  NUM_MASTERS*DATA_W/8  packed byte mask
m_respValid  out  NUM_MASTERS  one-cycle response pulse to the granted master
m_rdata  out  DATA_W  read data, shared by all masters; valid only with m_respValid
m_err  out  1  high with m_respValid when the response is a timeout
s_reqValid  out  1  request to slave
s_addr  out  ADDR_W  latched address
s_size  out  2  latched size
s_wen  out  1  latched write enable
s_wdata  out  DATA_W  latched write data
s_wmask  out  DATA_W/8  latched mask
s_respValid  in  1  slave response pulse
s_rdata  in  DATA_W  slave read data
grant  out  max(1,$clog2(NUM_MASTERS))  index of current/last granted master
late_resp  out  1  sticky: s_respValid seen while IDLE

Behaviour:
- Reset values: state=IDLE, s_reqValid=0, s_addr/s_size/s_wen/s_wdata/s_wmask=0, grant=NUM_MASTERS-1 (master 0 has first priority), timeout counter=0, late_resp=0.
- Reset mid-transaction aborts it. No response is issued. A later s_respValid is ignored and sets late_resp.
- IDLE state:
  - Each cycle, the master to grant is the first i with m_reqValid[i]=1, scanning from (grant+1) mod N and wrapping.
  - If any request is present: on the next edge, grant <= i, all s_* request fields are latched from master i, s_reqValid <= 1, counter <= 0, state <= WAIT.
  - If no request is present: stay in IDLE. grant is unchanged.
- WAIT state:
  - s_reqValid=1 and s_* fields are stable for the whole state. Master input changes are ignored.
  - If s_respValid=1: m_respValid[grant]=1 combinationally that cycle, m_rdata=s_rdata, m_err=0. Next edge: s_reqValid <= 0, state <= IDLE.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: m_respValid[grant]=1 that cycle, m_rdata=ERR_DATA (truncated or zero-extended to DATA_W), m_err=1. Next edge: s_reqValid <= 0, state <= IDLE.
  - Else: counter increments.
  - If s_respValid and timeout coincide, the slave response wins (m_err=0).
- Latency:
  - Request sampled in IDLE at cycle t gives s_reqValid=1 at t+1.
  - s_respValid at cycle k gives m_respValid at k (zero-cycle pass-through) and IDLE at k+1.
  - Minimum turnaround is 2 cycles per transaction. Back-to-back requests are arbitrated in the IDLE cycle k+1.
- Masters must drop m_reqValid in the cycle after m_respValid unless they are issuing a new request. A held request is treated as a new request.
- m_respValid bits other than grant are always 0. All m_respValid=0 outside WAIT.
- m_rdata=s_rdata and m_err=0 whenever no response is active.
- NUM_MASTERS=1: arbitration is degenerate, grant is always 0, and behaviour is otherwise identical.

Test Plan:
- Single read: m_reqValid=01, m_addr[0]=0x8000_0000; slave responds 3 cycles after s_reqValid with 0x1234_5678 -> s_addr=0x8000_0000, s_wen=0; m_respValid=01 for exactly one cycle with m_rdata=0x1234_5678, m_err=0; 2+3 cycles from request to response.
- Contention: both masters request from reset -> master 0 granted first, then master 1; with both held continuously, grants alternate 0,1,0,1.
- Write latching: master 1 requests write addr=0x100, wdata=0xCAFE_F00D, wmask=4'b0011; master 1 changes wdata during WAIT -> s_wdata stays 0xCAFE_F00D and s_wmask stays 0011 until response.
- Timeout: TIMEOUT=8, slave silent -> m_respValid pulses in cycle 8 of WAIT with m_rdata=0xDEADBEEF, m_err=1; a later s_respValid sets late_resp=1.
- Coincident timeout and response: TIMEOUT=4, s_respValid in the final WAIT cycle -> m_err=0 and m_rdata equals slave data.
- Reset mid-WAIT: assert reset during WAIT -> s_reqValid=0 immediately, grant=N-1, no m_respValid; after release, master 0 wins first arbitration.
